div_unsigned_seq_32: RTL and testbench

- Multi-cycle 32-bit unsigned restoring divider for the ALU divide path.
- Sits directly upstream of RC_ADD_SUB_32: drives its A/B/SnA inputs every iteration and consumes Y/CO to decide each quotient bit.
- One iteration per clock; START/BUSY/DONE handshake toward the ALU control.

---
 rtl/div_unsigned_seq_32.sv | 123 ++++++++++++
 tb/tb_div_unsigned_seq_32.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/div_unsigned_seq_32.sv
// rtl/div_unsigned_seq_32.sv - multi-cycle 32-bit unsigned restoring divider
// Also holds the ripple-carry add/sub slice the divider iterates through.

module RC_ADD_SUB_32 #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             SnA,
   output logic [WIDTH-1:0] Y,
   output logic             CO
);
   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] bx;

   // SnA=1 selects A-B as A + ~B + 1; CO=1 then means no borrow
   always_comb begin
      bx   = B ^ {WIDTH{SnA}};
      c    = '0;
      Y    = '0;
      c[0] = SnA;
      for (int i = 0; i < WIDTH; i++) begin
         Y[i]   = A[i] ^ bx[i] ^ c[i];
         c[i+1] = (A[i] & bx[i]) | (c[i] & (A[i] ^ bx[i]));
      end
      CO = c[WIDTH];
   end
endmodule

module div_unsigned_seq_32 #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [WIDTH-1:0] DIVIDEND,
   input  logic [WIDTH-1:0] DIVISOR,
   output logic [WIDTH-1:0] QUOTIENT,
   output logic [WIDTH-1:0] REMAINDER,
   output logic             BUSY,
   output logic             DONE,
   output logic             DIV_BY_ZERO
);
   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] r, q, d, s, y, r_nx, q_nx;
   logic [CNT_W-1:0] cnt;
   logic             co, ok, last;

   // The bit shifted out of R extends the partial remainder to WIDTH+1 bits
   assign s    = {r[WIDTH-2:0], q[WIDTH-1]};
   assign ok   = r[WIDTH-1] | co;
   assign r_nx = ok ? y : s;
   assign q_nx = {q[WIDTH-2:0], ok};
   assign last = (cnt == CNT_W'(WIDTH - 1));

   RC_ADD_SUB_32 #(.WIDTH(WIDTH)) u_addsub (
      .A   (s),
      .B   (d),
      .SnA (1'b1),
      .Y   (y),
      .CO  (co)
   );

   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (START) state_nx = (DIVISOR == '0) ? FIN : RUN;
         RUN:  if (last) state_nx = FIN;
         FIN:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r           <= '0;
         q           <= '0;
         d           <= '0;
         cnt         <= '0;
         QUOTIENT    <= '0;
         REMAINDER   <= '0;
         DIV_BY_ZERO <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (START) begin
                  d   <= DIVISOR;
                  q   <= DIVIDEND;
                  r   <= '0;
                  cnt <= '0;
                  if (DIVISOR == '0) begin
                     QUOTIENT    <= '1;
                     REMAINDER   <= DIVIDEND;
                     DIV_BY_ZERO <= 1'b1;
                  end
               end
            end
            RUN: begin
               r   <= r_nx;
               q   <= q_nx;
               cnt <= cnt + CNT_W'(1);
               if (last) begin
                  QUOTIENT    <= q_nx;
                  REMAINDER   <= r_nx;
                  DIV_BY_ZERO <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign BUSY = (state == RUN);
   assign DONE = (state == FIN);
endmodule

// File: tb/tb_div_unsigned_seq_32.sv
// tb/tb_div_unsigned_seq_32.sv - directed self-checking bench for div_unsigned_seq_32

module tb_div_unsigned_seq_32;
   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        START = 1'b0;
   logic [31:0] DIVIDEND = '0;
   logic [31:0] DIVISOR = '0;
   logic [31:0] QUOTIENT, REMAINDER;
   logic        BUSY, DONE, DIV_BY_ZERO;

   int n_checks = 0;
   int n_errors = 0;

   div_unsigned_seq_32 dut (
      .CLK         (CLK),
      .RST         (RST),
      .START       (START),
      .DIVIDEND    (DIVIDEND),
      .DIVISOR     (DIVISOR),
      .QUOTIENT    (QUOTIENT),
      .REMAINDER   (REMAINDER),
      .BUSY        (BUSY),
      .DONE        (DONE),
      .DIV_BY_ZERO (DIV_BY_ZERO)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Issue one divide, then follow it to DONE and check latency and results
   task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input logic ez);
      int cycles;
      int busy_cnt;
      @(negedge CLK);
      DIVIDEND = a;
      DIVISOR  = b;
      START    = 1'b1;
      @(negedge CLK);
      START    = 1'b0;
      DIVIDEND = ~a;
      DIVISOR  = 32'h0000_0003;
      cycles   = 0;
      busy_cnt = 0;
      while (!DONE && cycles < 100) begin
         if (BUSY) busy_cnt++;
         @(negedge CLK);
         cycles++;
      end
      check({tag, " latency"}, cycles, ez ? 32'd0 : 32'd32);
      check({tag, " busy"}, busy_cnt, ez ? 32'd0 : 32'd32);
      check({tag, " busy_at_done"}, {31'd0, BUSY}, 32'd0);
      check({tag, " quotient"}, QUOTIENT, eq);
      check({tag, " remainder"}, REMAINDER, er);
      check({tag, " div_by_zero"}, {31'd0, DIV_BY_ZERO}, {31'd0, ez});
      @(negedge CLK);
      check({tag, " done_single"}, {31'd0, DONE}, 32'd0);
   endtask

   initial begin
      int done_cnt;
      int done_at [2];
      bit saw_done;

      repeat (2) @(negedge CLK);
      check("rst quotient", QUOTIENT, 32'd0);
      check("rst remainder", REMAINDER, 32'd0);
      check("rst busy", {31'd0, BUSY}, 32'd0);
      check("rst done", {31'd0, DONE}, 32'd0);
      check("rst dbz", {31'd0, DIV_BY_ZERO}, 32'd0);
      RST = 1'b0;

      run_div("basic", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
      run_div("mixed", 32'hDEADBEEF, 32'hCAFEBABE, 32'd1, 32'h13AF0431, 1'b0);
      run_div("by_one", 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0);
      run_div("big_div", 32'hFFFFFFFF, 32'h80000001, 32'd1, 32'h7FFFFFFE, 1'b0);
      run_div("small_num", 32'd5, 32'hFFFFFFFF, 32'd0, 32'd5, 1'b0);
      run_div("div_zero", 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1'b1);
      run_div("after_zero", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

      // START held high; operands changed during RUN
      @(negedge CLK);
      DIVIDEND = 32'd100;
      DIVISOR  = 32'd7;
      START    = 1'b1;
      done_cnt = 0;
      for (int i = 0; i < 75; i++) begin
         @(negedge CLK);
         if (i == 0) begin
            DIVIDEND = 32'd9;
            DIVISOR  = 32'd3;
         end
         if (DONE) begin
            if (done_cnt < 2) done_at[done_cnt] = i;
            if (done_cnt == 0) begin
               check("held q1", QUOTIENT, 32'd14);
               check("held r1", REMAINDER, 32'd2);
            end else if (done_cnt == 1) begin
               check("held q2", QUOTIENT, 32'd3);
               check("held r2", REMAINDER, 32'd0);
            end
            done_cnt++;
         end
         if (i == 66) START = 1'b0;
      end
      check("held done_count", done_cnt, 32'd2);
      check("held done1_at", done_at[0], 32'd32);
      check("held done2_at", done_at[1], 32'd66);

      // Reset on the 10th RUN cycle
      @(negedge CLK);
      DIVIDEND = 32'd200;
      DIVISOR  = 32'd9;
      START    = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      repeat (9) @(negedge CLK);
      check("pre_rst busy", {31'd0, BUSY}, 32'd1);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      check("abort busy", {31'd0, BUSY}, 32'd0);
      check("abort done", {31'd0, DONE}, 32'd0);
      check("abort quotient", QUOTIENT, 32'd0);
      check("abort remainder", REMAINDER, 32'd0);
      check("abort dbz", {31'd0, DIV_BY_ZERO}, 32'd0);
      saw_done = 1'b0;
      repeat (40) begin
         @(negedge CLK);
         if (DONE || BUSY) saw_done = 1'b1;
      end
      check("abort no_done", {31'd0, saw_done}, 32'd0);

      run_div("post_rst", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
